plab5_mcore_net_msg_to_mem_req_queue: RTL
=========================================

// Module: plab5_mcore_net_msg_to_mem_req_queue
// PURPOSE
//  Bank-side ingress stage: consumes request network messages (split control/data) addressed to one memory bank,
//  unpacks them back into memory request messages, buffers them in a 2-entry queue and presents them to the bank.
//  Enforces a domain check: untrusted-domain requests into the protected address window are dropped and flagged.
// PARAMETERS
//  p_mem_opaque_nbits   8        memory opaque width (mo); high ns bits carry requesting core id, passed through
//  p_mem_addr_nbits     32       memory address width (ma)
//  p_mem_data_nbits     32       memory data width (md); len field = $clog2(md/8) = 2 bits
//  p_net_opaque_nbits   4        network opaque width (no); ignored on ingress
//  p_net_srcdest_nbits  3        network src/dest width (ns)
//  p_sec_addr_lo        32'h4000 protected window lower bound (inclusive)
//  p_sec_addr_hi        32'hc000 protected window upper bound (exclusive)
//  derived: npc = 3+mo+ma+2 = 45; ctrl msg = {dest[ns],src[ns],opaque[no],req_domain,payload_ctrl[npc]} = 56b
//           mem req = {type[3],opaque[mo],addr[ma],len[2],data[md]} = 77b
// PORTS
//  clk              in   1    clock
//  reset            in   1    asynchronous, active-high reset
//  domain           in   1    bank domain (0 trusted, 1 untrusted); qualifies bank-side labels
//  in_val           in   1    network message valid
//  in_rdy           out  1    network message ready
//  in_msg_control   in   56   network ctrl msg incl. req_domain bit at [npc]
//  in_msg_data      in   32   network data payload (mem req data field)
//  out_val          out  1    memory request valid
//  out_rdy          in   1    memory request ready
//  out_msg          out  77   reassembled memory request
//  viol             out  1    sticky domain-violation flag
//  viol_clr         in   1    clears viol (and viol_cnt when enabled)
//  viol_cnt         out  8    violation count (only with PLAB5_MCORE_NET_MEM_VIOL_CNT_EN)
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-transfer): queue emptied, out_val=0, in_rdy=1, viol=0, viol_cnt=0.
//  - Handshake: transfer when val&&rdy on the same posedge; val must not depend on rdy.
//  - in_rdy = !full (2 entries); no combinational bypass; out_val = !empty; out_msg = head entry (registered).
//  - Latency: message accepted at edge N visible on out_msg in cycle N+1 (if queue empty).
//  - Unpack: type/opaque/addr/len from payload_ctrl, data from in_msg_data; opaque passed unmodified.
//  - Deny rule: req_domain==1 && p_sec_addr_lo <= addr < p_sec_addr_hi (unsigned compare, full ma bits).
//  - Denied msg: accepted (consumes in_rdy slot), NOT enqueued; viol set next edge; viol_cnt++ saturating at 255.
//  - Simultaneous enq & deq with 1 entry: both occur, count stays 1, order preserved (FIFO).
//  - Simultaneous enq & deq when full: deq only (in_rdy=0 that cycle).
//  - viol_clr and new violation same cycle: violation wins (viol=1, viol_cnt=1).
//  - Pointers: 1-bit wr/rd pointers wrap 1->0; count 0..2.
//  - Violation FSM: OK -> VIOL on denied accept; VIOL -> OK on viol_clr without new violation.
// CONFIGURATION
//  PLAB5_MCORE_NET_MEM_VIOL_CNT_EN defined: 8-bit saturating viol_cnt port and counter present.
//  Undefined: viol_cnt port and counter absent; only sticky viol flag.
// STRUCTURE
//  Shared package/header: ctrl/mem field-slice macros, npc/ctrl width constants, violation FSM state encodings.
//  One sub-module: plab5_mcore_req_queue2 (2-entry FIFO, val/rdy, parameterised width).
//  Top: unpack + deny compare + violation FSM/counter.
// TESTING
//  1 trusted rd addr 0x0100, out_rdy=1 -> out_val cycle+1, out_msg.addr=0x0100, opaque unchanged.
//  2 req_domain=1 wr addr 0x8000 -> in_rdy=1, no out_val, viol=1, viol_cnt=1; addr 0xc000 -> forwarded.
//  3 out_rdy=0, send 3 msgs -> in_rdy=0 after 2; release -> msgs out in order A,B then C.
//  4 1 entry held, enq+deq same edge for 10 cycles -> count stays 1, no drop, no duplicate.
//  5 assert reset with 2 entries queued mid-stream -> out_val=0, in_rdy=1 immediately (async).
//  6 300 denied msgs -> viol_cnt=255 saturated; viol_clr -> viol=0, viol_cnt=0; clr+violation -> 1.

Source files
------------

// File: rtl/plab5_mcore_net_msg_to_mem_req_queue_pkg.sv
// Shared widths, field-position helpers and violation-FSM encoding for the
// bank-side network-to-memory request ingress stage.
package plab5_mcore_net_msg_to_mem_req_queue_pkg;

  localparam int unsigned c_mem_type_nbits = 3;
  localparam int unsigned c_viol_cnt_nbits = 8;

  typedef enum logic {
    VIOL_OK  = 1'b0,
    VIOL_SET = 1'b1
  } viol_state_e;

  function automatic int unsigned len_nbits(input int unsigned data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  // payload_ctrl = {type, opaque, addr, len}
  function automatic int unsigned npc_nbits(input int unsigned mo,
                                            input int unsigned ma,
                                            input int unsigned md);
    return c_mem_type_nbits + mo + ma + len_nbits(md);
  endfunction

  // ctrl msg = {dest, src, net_opaque, req_domain, payload_ctrl}
  function automatic int unsigned ctrl_nbits(input int unsigned ns,
                                             input int unsigned no,
                                             input int unsigned npc);
    return 2 * ns + no + 1 + npc;
  endfunction

endpackage

// File: rtl/plab5_mcore_req_queue2.sv
// Two-entry val/rdy FIFO with registered output and no enqueue-to-dequeue
// bypass; enqueue is refused while full even if a dequeue happens that cycle.
module plab5_mcore_req_queue2 #(
  parameter int unsigned p_nbits = 77
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg
);

  logic [p_nbits-1:0] entries [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count;
  logic               enq;
  logic               deq;

  assign enq_rdy = (count != 2'd2);
  assign deq_val = (count != 2'd0);
  assign deq_msg = entries[rd_ptr];
  assign enq     = enq_val && enq_rdy;
  assign deq     = deq_val && deq_rdy;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates its
  // visibility, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (enq) entries[wr_ptr] <= enq_msg;
  end

endmodule

// File: rtl/plab5_mcore_net_msg_to_mem_req_queue.sv
// Bank ingress: unpacks network request messages, drops untrusted accesses to
// the protected window, queues the rest. PLAB5_MCORE_NET_MEM_VIOL_CNT_EN adds viol_cnt.
module plab5_mcore_net_msg_to_mem_req_queue
  import plab5_mcore_net_msg_to_mem_req_queue_pkg::*;
#(
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_addr_nbits    = 32,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3,
  parameter logic [p_mem_addr_nbits-1:0] p_sec_addr_lo = 'h4000,
  parameter logic [p_mem_addr_nbits-1:0] p_sec_addr_hi = 'hc000,
  localparam int unsigned c_len_nbits  = len_nbits(p_mem_data_nbits),
  localparam int unsigned c_npc_nbits  = npc_nbits(p_mem_opaque_nbits, p_mem_addr_nbits,
                                                   p_mem_data_nbits),
  localparam int unsigned c_ctrl_nbits = ctrl_nbits(p_net_srcdest_nbits, p_net_opaque_nbits,
                                                    c_npc_nbits),
  localparam int unsigned c_req_nbits  = c_npc_nbits + p_mem_data_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        domain,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [c_ctrl_nbits-1:0]     in_msg_control,
  input  logic [p_mem_data_nbits-1:0] in_msg_data,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [c_req_nbits-1:0]      out_msg,
`ifdef PLAB5_MCORE_NET_MEM_VIOL_CNT_EN
  output logic [c_viol_cnt_nbits-1:0] viol_cnt,
`endif
  output logic                        viol,
  input  logic                        viol_clr
);

  logic [c_npc_nbits-1:0]      payload_ctrl;
  logic                        req_domain;
  logic [p_mem_addr_nbits-1:0] req_addr;
  logic                        deny;
  logic                        deny_accept;
  viol_state_e                 state;
  viol_state_e                 state_next;

  assign payload_ctrl = in_msg_control[c_npc_nbits-1:0];
  assign req_domain   = in_msg_control[c_npc_nbits];
  assign req_addr     = payload_ctrl[c_len_nbits +: p_mem_addr_nbits];

  assign deny = req_domain && (req_addr >= p_sec_addr_lo) && (req_addr < p_sec_addr_hi);

  // A denied message still uses the ready slot, so it is only accepted when
  // the queue could have taken it.
  assign deny_accept = in_val && in_rdy && deny;

  plab5_mcore_req_queue2 #(
    .p_nbits (c_req_nbits)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in_val && !deny),
    .enq_rdy (in_rdy),
    .enq_msg ({payload_ctrl, in_msg_data}),
    .deq_val (out_val),
    .deq_rdy (out_rdy),
    .deq_msg (out_msg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= VIOL_OK;
    else       state <= state_next;
  end

  // NOTE: the next-state default is assigned first so no path leaves
  // state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      VIOL_OK:  if (deny_accept)              state_next = VIOL_SET;
      VIOL_SET: if (viol_clr && !deny_accept) state_next = VIOL_OK;
      default:                                state_next = VIOL_OK;
    endcase
  end

  always_comb begin
    viol = (state == VIOL_SET);
  end

`ifdef PLAB5_MCORE_NET_MEM_VIOL_CNT_EN
  // A violation arriving with a clear restarts the count at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      viol_cnt <= '0;
    end else if (deny_accept) begin
      if (viol_clr)            viol_cnt <= c_viol_cnt_nbits'(1);
      else if (viol_cnt != '1) viol_cnt <= viol_cnt + c_viol_cnt_nbits'(1);
    end else if (viol_clr) begin
      viol_cnt <= '0;
    end
  end
`endif

  // Routing fields and the bank label carry no meaning past this stage.
  logic unused_bits;
  assign unused_bits = ^{domain, in_msg_control[c_ctrl_nbits-1:c_npc_nbits+1]};

endmodule
